// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the queued UART transmitter: a producer offers a word
// with in_valid, and the transmitter accepts it on an edge where in_ready is high.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output data, output in_valid, input in_ready);
    modport slave  (input data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO. Frames are start, data (LSB first),
// optional parity and one or two stop bits, sent back-to-back while words are queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    uart_tx_fifo_if.slave                     wr,
    output logic                              TxD,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head;
    logic                 pop, shift_en, wr_en, bit_end, fifo_nonempty;

    assign wr.in_ready    = !reset && (count_q < CW'(FIFO_DEPTH));
    assign wr_en          = wr.in_valid && wr.in_ready;
    assign bit_end        = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign fifo_nonempty  = (count_q != '0);
    assign head           = mem[rptr_q];
    assign TxD            = tx_q;
    assign busy           = (state_q != S_IDLE);
    assign fifo_count     = count_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        shift_en   = 1'b0;

        if (state_q != S_IDLE)
            timer_d = bit_end ? '0 : timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        // Pop straight into the next start bit so frames stay contiguous.
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        count_d = count_q + CW'(wr_en) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr_q] <= wr.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            if (wr_en)
                wptr_q <= wptr_q + 1'b1;
            // The word and its parity are captured at pop, so later writes cannot disturb them.
            if (pop) begin
                rptr_q  <= rptr_q + 1'b1;
                shift_q <= head;
                par_q   <= (PARITY == 1) ? ~^head : ^head;
            end else if (shift_en) begin
                shift_q <= shift_q >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances cover 8N1, 7E2, 8O1 and 8E1 frames; a per-instance
// line monitor decodes frames and checks them against queued expectations.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    typedef struct packed {
        logic [8:0] w;
        logic       p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst0 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp0[$], exp1[$], exp2[$], exp3[$];
    int   starts0[$];

    logic       tx0, tx1, tx2, tx3;
    logic       bz0, bz1, bz2, bz3;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;
    logic [3:0] tx_all;
    assign tx_all = {tx3, tx2, tx1, tx0};

    uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if3 ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(rst | rst0), .wr(if0), .TxD(tx0), .busy(bz0), .fifo_count(cnt0));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(rst), .wr(if1), .TxD(tx1), .busy(bz1), .fifo_count(cnt1));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset(rst), .wr(if2), .TxD(tx2), .busy(bz2), .fifo_count(cnt2));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .reset(rst), .wr(if3), .TxD(tx3), .busy(bz3), .fifo_count(cnt3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_exp(input int idx, input exp_t e);
        case (idx)
            0: exp0.push_back(e);
            1: exp1.push_back(e);
            2: exp2.push_back(e);
            default: exp3.push_back(e);
        endcase
    endfunction

    function automatic bit pop_exp(input int idx, output exp_t e);
        e = '0;
        case (idx)
            0: begin if (exp0.size() == 0) return 1'b0; e = exp0.pop_front(); end
            1: begin if (exp1.size() == 0) return 1'b0; e = exp1.pop_front(); end
            2: begin if (exp2.size() == 0) return 1'b0; e = exp2.pop_front(); end
            default: begin if (exp3.size() == 0) return 1'b0; e = exp3.pop_front(); end
        endcase
        return 1'b1;
    endfunction

    function automatic logic get_ready(input int idx);
        case (idx)
            0: return if0.in_ready;
            1: return if1.in_ready;
            2: return if2.in_ready;
            default: return if3.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int idx);
        case (idx)
            0: return bz0;
            1: return bz1;
            2: return bz2;
            default: return bz3;
        endcase
    endfunction

    function automatic int get_cnt(input int idx);
        case (idx)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    task automatic set_in(input int idx, input logic v, input logic [8:0] w);
        case (idx)
            0: begin if0.in_valid = v; if0.data = w[7:0]; end
            1: begin if1.in_valid = v; if1.data = w[6:0]; end
            2: begin if2.in_valid = v; if2.data = w[7:0]; end
            default: begin if3.in_valid = v; if3.data = w[7:0]; end
        endcase
    endtask

    // Called just after a rising edge; returns the cycle number of the accepting edge.
    task automatic send(input int idx, input logic [8:0] w, input logic pb, input bit push, output int acc);
        int n;
        n = 0;
        set_in(idx, 1'b1, w);
        while (!get_ready(idx) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        @(posedge clk); #1;
        acc = cyc;
        set_in(idx, 1'b0, 9'h0);
        if (push) push_exp(idx, '{w: w, p: pb});
        $display("write inst%0d word %h accepted at cycle %0d", idx, w, acc);
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int n;
        n = 0;
        while (!(get_busy(idx) == 1'b0 && get_cnt(idx) == 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", int'(n < budget), 1);
    endtask

    task automatic measure_busy(input int idx, output int bc);
        bc = 0;
        @(posedge clk); #1;
        while (get_busy(idx) && bc < 200) begin
            bc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic monitor(input int idx, input int nb, input int par, input int stops);
        int   total;
        logic v;
        logic bv [16];
        bit   ok, ab;
        logic [8:0] w;
        exp_t e;
        total = 1 + nb + ((par != 0) ? 1 : 0) + stops;
        forever begin
            @(negedge clk);
            if (tx_all[idx] === 1'b0 && !(rst || rst0)) begin
                ok = 1'b1;
                ab = 1'b0;
                if (idx == 0) starts0.push_back(cyc);
                for (int b = 0; b < total && !ab; b++) begin
                    for (int c = 0; c < CPB && !ab; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst || rst0) ab = 1'b1;
                        v = tx_all[idx];
                        if (c == 0) bv[b] = v;
                        else if (v !== bv[b]) ok = 1'b0;
                    end
                end
                if (!ab) begin
                    w = '0;
                    for (int k = 0; k < nb; k++) w[k] = bv[1 + k];
                    if (!pop_exp(idx, e)) begin
                        chk("unexpected_frame", int'(w), -1);
                    end else begin
                        $display("frame inst%0d word %h want %h", idx, w, e.w);
                        chk("frame_word", int'(w), int'(e.w));
                        chk("bit_hold", int'(ok), 1);
                        if (par != 0) chk("parity_bit", int'(bv[1 + nb]), int'(e.p));
                        for (int s = 0; s < stops; s++) chk("stop_bit", int'(bv[total - 1 - s]), 1);
                    end
                end
            end
        end
    endtask

    initial monitor(0, 8, 0, 1);
    initial monitor(1, 7, 2, 2);
    initial monitor(2, 8, 1, 1);
    initial monitor(3, 8, 2, 1);

    initial begin
        int acc, bc, ca, bad;
        int a [1:6];
        for (int i = 0; i < 4; i++) set_in(i, 1'b0, 9'h0);

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_txd", int'(tx0), 1);
        chk("rst_busy", int'(bz0), 0);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_ready_low", int'(if0.in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(if0.in_ready), 1);
        @(posedge clk); #1;

        // 8N1 single word: latency and 40-cycle frame
        send(0, 9'h0A5, 1'b0, 1'b1, acc);
        chk("lat_count1", int'(cnt0), 1);
        chk("lat_busy0", int'(bz0), 0);
        measure_busy(0, bc);
        chk("busy_len_8n1", bc, 40);
        chk("txd_idle_after", int'(tx0), 1);

        // 7E2 frame is 44 cycles
        send(1, 9'h007, 1'b1, 1'b1, acc);
        measure_busy(1, bc);
        chk("busy_len_7e2", bc, 44);

        // Odd and even parity on 0x00 and 0xFF
        send(2, 9'h000, 1'b1, 1'b1, acc);
        send(2, 9'h0FF, 1'b1, 1'b1, acc);
        send(3, 9'h000, 1'b0, 1'b1, acc);
        send(3, 9'h0FF, 1'b0, 1'b1, acc);
        wait_idle(2, 300);
        wait_idle(3, 300);

        // FIFO fill: six words, back-to-back frames
        starts0.delete();
        for (int k = 1; k <= 6; k++) begin
            send(0, 9'(k), 1'b0, 1'b1, a[k]);
            if (k == 5) begin
                chk("full_count", int'(cnt0), 4);
                chk("full_ready_low", int'(if0.in_ready), 0);
            end
        end
        chk("sixth_accept_delay", a[6] - a[1], 42);
        wait_idle(0, 400);
        chk("burst_frames", starts0.size(), 6);
        for (int k = 1; k < starts0.size(); k++) chk("burst_gap", starts0[k] - starts0[k-1], 40);

        // Simultaneous write and pop at count 2
        @(posedge clk); #1;
        send(0, 9'h011, 1'b0, 1'b1, ca);
        send(0, 9'h022, 1'b0, 1'b1, acc);
        send(0, 9'h033, 1'b0, 1'b1, acc);
        while (cyc < ca + 40) begin @(posedge clk); #1; end
        chk("pre_simul_count", int'(cnt0), 2);
        send(0, 9'h044, 1'b0, 1'b1, acc);
        chk("simul_edge", acc - ca, 41);
        chk("simul_count", int'(cnt0), 2);
        wait_idle(0, 400);

        // Reset mid data bit 3 with two words queued
        @(posedge clk); #1;
        send(0, 9'h03C, 1'b0, 1'b0, ca);
        send(0, 9'h0AA, 1'b0, 1'b0, acc);
        send(0, 9'h0BB, 1'b0, 1'b0, acc);
        while (cyc < ca + 18) begin @(posedge clk); #1; end
        chk("pre_rst_count", int'(cnt0), 2);
        rst0 = 1'b1;
        set_in(0, 1'b1, 9'h055);
        #1;
        chk("rst_mid_ready", int'(if0.in_ready), 0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        set_in(0, 1'b0, 9'h0);
        chk("rst_mid_txd", int'(tx0), 1);
        chk("rst_mid_busy", int'(bz0), 0);
        chk("rst_mid_count", int'(cnt0), 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || bz0 !== 1'b0) bad++;
        end
        chk("no_frames_after_rst", bad, 0);

        chk("exp0_left", exp0.size(), 0);
        chk("exp1_left", exp1.size(), 0);
        chk("exp2_left", exp2.size(), 0);
        chk("exp3_left", exp3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
